// File: rtl/csr_unit.sv
// Machine-mode CSR file: RW/RS/RC access, trap entry and mret, timer interrupt, illegal-access flag.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int HART_ID = 0,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_src,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_illegal,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_epc,
  output logic [DATA_WIDTH-1:0] trap_vector,
  input  logic                  mret,
  output logic [DATA_WIDTH-1:0] mret_target,
  input  logic                  irq_timer,
  output logic                  irq_pending,
  input  logic                  instret_inc
);

  localparam int W = DATA_WIDTH;
  typedef logic [W-1:0] word_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  localparam word_t HART_VAL = word_t'(HART_ID);

  // Only modes 00 (direct) and 01 (vectored) are legal; anything else becomes direct.
  function automatic word_t mtvec_legal(input word_t v);
    word_t r;
    r = v;
    if (v[1:0] != 2'b01) r[1:0] = 2'b00;
    return r;
  endfunction

  logic  mst_mie, mst_mpie, mie_mtie, mtip_q;
  word_t mtvec_q, mscratch_q, mepc_q, mcause_q;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`endif

  logic  known, read_only, wr_attempt, wr_en;
  word_t wdata;

  always_comb begin
    csr_rdata = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      A_MSTATUS: begin
        csr_rdata[3]     = mst_mie;
        csr_rdata[7]     = mst_mpie;
        csr_rdata[12:11] = 2'b11;
      end
      A_MIE:      csr_rdata[7] = mie_mtie;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MIP: begin
        csr_rdata[7] = mtip_q;
        read_only    = 1'b1;
      end
      A_MHARTID: begin
        csr_rdata = HART_VAL;
        read_only = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:   csr_rdata = word_t'(mcycle_q);
      A_MINSTRET: csr_rdata = word_t'(minstret_q);
      A_MCYCLEH: begin
        if (W == 32) csr_rdata = word_t'(mcycle_q >> 32);
        else known = 1'b0;
      end
      A_MINSTRETH: begin
        if (W == 32) csr_rdata = word_t'(minstret_q >> 32);
        else known = 1'b0;
      end
`endif
      default: known = 1'b0;
    endcase
  end

  // RS/RC with a zero source is a pure read and never modifies state.
  always_comb begin
    wr_attempt  = (csr_op == OP_RW) || (csr_src != '0);
    csr_illegal = (csr_op != OP_NONE) && (!known || (read_only && wr_attempt));
    wr_en       = (csr_op != OP_NONE) && wr_attempt && known && !read_only && !trap_valid;
    case (csr_op)
      OP_RW:   wdata = csr_src;
      OP_RS:   wdata = csr_rdata | csr_src;
      OP_RC:   wdata = csr_rdata & ~csr_src;
      default: wdata = csr_rdata;
    endcase
  end

  always_comb begin
    trap_vector = mtvec_q & ~word_t'(3);
    if (mtvec_q[1:0] == 2'b01 && trap_cause[W-1])
      trap_vector = trap_vector + (word_t'({1'b0, trap_cause[W-2:0]}) << 2);
  end

  assign mret_target = mepc_q;
  assign irq_pending = mst_mie & mie_mtie & mtip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_mtie   <= 1'b0;
      mtip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mtip_q <= irq_timer;
      if (trap_valid) begin
        mepc_q   <= trap_epc & ~word_t'(3);
        mcause_q <= trap_cause;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (wr_en) begin
        case (csr_addr)
          A_MSTATUS: begin
            mst_mie  <= wdata[3];
            mst_mpie <= wdata[7];
          end
          A_MIE:      mie_mtie   <= wdata[7];
          A_MTVEC:    mtvec_q    <= mtvec_legal(wdata);
          A_MSCRATCH: mscratch_q <= wdata;
          A_MEPC:     mepc_q     <= wdata & ~word_t'(3);
          A_MCAUSE:   mcause_q   <= wdata;
          default: ;
        endcase
      end else if (mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] wd64;
  logic cyc_lo_we, cyc_hi_we, ins_lo_we, ins_hi_we;

  always_comb begin
    wd64      = 64'(wdata);
    cyc_lo_we = wr_en && (csr_addr == A_MCYCLE);
    cyc_hi_we = wr_en && (csr_addr == A_MCYCLEH);
    ins_lo_we = wr_en && (csr_addr == A_MINSTRET);
    ins_hi_we = wr_en && (csr_addr == A_MINSTRETH);
  end

  // A write to either half replaces it and skips that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (cyc_lo_we)
        mcycle_q <= (W == 32) ? {mcycle_q[63:32], wd64[31:0]} : wd64;
      else if (cyc_hi_we)
        mcycle_q <= {wd64[31:0], mcycle_q[31:0]};
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (ins_lo_we)
        minstret_q <= (W == 32) ? {minstret_q[63:32], wd64[31:0]} : wd64;
      else if (ins_hi_we)
        minstret_q <= {wd64[31:0], minstret_q[31:0]};
      else if (instret_inc)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_instret;
  assign unused_instret = instret_inc;
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected output values, a negedge monitor compares.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_vector;
  logic        mret;
  logic [31:0] mret_target;
  logic        irq_timer;
  logic        irq_pending;
  logic        instret_inc;

  always #5 clk = ~clk;

  csr_unit #(.DATA_WIDTH(32), .HART_ID(0), .MTVEC_RESET(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_src(csr_src),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_vector(trap_vector),
    .mret(mret), .mret_target(mret_target), .irq_timer(irq_timer),
    .irq_pending(irq_pending), .instret_inc(instret_inc)
  );

  localparam int S_RDATA = 0, S_ILL = 1, S_TVEC = 2, S_MRET = 3, S_IRQ = 4;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        S_RDATA: act = csr_rdata;
        S_ILL:   act = {31'b0, csr_illegal};
        S_TVEC:  act = trap_vector;
        S_MRET:  act = mret_target;
        default: act = {31'b0, irq_pending};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_op = 2'b00; csr_src = '0; trap_valid = 1'b0; mret = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] s);
    csr_op = o; csr_addr = a; csr_src = s;
  endtask

  task automatic read(input logic [11:0] a, input logic [31:0] v, input string n);
    idle();
    csr_addr = a;
    push(S_RDATA, v, n);
    step();
  endtask

  initial begin
    rst = 1'b1; irq_timer = 1'b0; csr_addr = 12'h000;
    trap_cause = '0; trap_epc = '0;
    idle();
    step(); step();
    rst = 1'b0;

    csr_addr = 12'h305;
    push(S_RDATA, 32'h8000_0000, "reset_mtvec");
    push(S_IRQ, 32'h0, "reset_irq_pending");
    push(S_MRET, 32'h0, "reset_mret_target");
    step();
    read(12'hF14, 32'h0, "reset_mhartid");
    read(12'h300, 32'h0000_1800, "reset_mstatus");

    op(2'b01, 12'h300, 32'h88); step();
    op(2'b10, 12'h304, 32'h80); irq_timer = 1'b1; step();
    idle(); csr_addr = 12'h300;
    push(S_RDATA, 32'h0000_1888, "mstatus_rw");
    push(S_IRQ, 32'h1, "irq_pending_set");
    step();
    read(12'h304, 32'h80, "mie_rs");
    read(12'h344, 32'h80, "mip_mtip");
    op(2'b11, 12'h300, 32'h8); step();
    idle(); csr_addr = 12'h300;
    push(S_IRQ, 32'h0, "irq_pending_clear");
    push(S_RDATA, 32'h0000_1880, "mstatus_rc");
    step();
    irq_timer = 1'b0;

    op(2'b01, 12'h341, 32'hFFFF_FFFF); step();
    read(12'h341, 32'hFFFF_FFFC, "mepc_mask");
    op(2'b01, 12'h300, 32'hFFFF_FFFF); step();
    read(12'h300, 32'h0000_1888, "mstatus_mask");
    op(2'b01, 12'h305, 32'h0000_1002); step();
    read(12'h305, 32'h0000_1000, "mtvec_mode_illegal");
    op(2'b01, 12'h304, 32'hFFFF_FFFF); step();
    read(12'h304, 32'h80, "mie_mask");

    op(2'b10, 12'hF14, 32'h0);
    push(S_ILL, 32'h0, "rs_zero_ro_legal");
    step();
    op(2'b01, 12'hF14, 32'h5);
    push(S_ILL, 32'h1, "rw_mhartid_illegal");
    step();
    read(12'hF14, 32'h0, "mhartid_unchanged");
    op(2'b01, 12'h344, 32'h80);
    push(S_ILL, 32'h1, "rw_mip_illegal");
    step();
    op(2'b01, 12'h123, 32'h1);
    push(S_ILL, 32'h1, "unknown_illegal");
    push(S_RDATA, 32'h0, "unknown_reads_zero");
    step();

    op(2'b01, 12'h305, 32'h0000_1001); step();
    idle();
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_epc = 32'h123;
    push(S_TVEC, 32'h0000_101C, "vectored_irq");
    step();
    idle();
    trap_cause = 32'h2;
    push(S_TVEC, 32'h0000_1000, "vectored_exception_base");
    push(S_MRET, 32'h120, "mret_target_after_trap");
    csr_addr = 12'h341; push(S_RDATA, 32'h120, "trap_mepc");
    step();
    read(12'h342, 32'h8000_0007, "trap_mcause");
    read(12'h300, 32'h0000_1880, "trap_mstatus");
    mret = 1'b1; step();
    read(12'h300, 32'h0000_1888, "mret_mstatus");

    op(2'b01, 12'h341, 32'h400);
    trap_valid = 1'b1; trap_cause = 32'h5; trap_epc = 32'h207;
    step();
    read(12'h341, 32'h204, "trap_beats_write");
    read(12'h342, 32'h5, "trap_cause_sync");

    op(2'b01, 12'h340, 32'h55); mret = 1'b1; step();
    read(12'h300, 32'h0000_1880, "write_beats_mret");
    read(12'h340, 32'h55, "mscratch_written");

    rst = 1'b1;
    op(2'b01, 12'h340, 32'h77); trap_valid = 1'b1;
    step();
    rst = 1'b0;
    read(12'h340, 32'h0, "reset_beats_write");
    read(12'h305, 32'h8000_0000, "reset_mtvec_again");

`ifdef CSR_COUNTERS_EN
    op(2'b01, 12'hB00, 32'hFFFF_FFFF); step();
    idle(); step();
    read(12'hB80, 32'h1, "mcycleh_carry");
    read(12'hB00, 32'h1, "mcycle_wrapped_low");
`else
    op(2'b10, 12'hB00, 32'h1);
    push(S_ILL, 32'h1, "counter_absent_illegal");
    push(S_RDATA, 32'h0, "counter_absent_read");
    step();
`endif

    idle();
    step(); step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
